// File: rtl/writeback_stage_if.sv
// Bundle of pipeline-side, register-file and output-port signals for the write-back stage.
// The slave modport is the stage itself; the master modport is whoever drives the pipeline and device.
interface writeback_stage_if #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int OUT_DEPTH = 4
);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    logic              reg_write_in;
    logic [1:0]        wb_sel_in;
    logic [ADDR_W-1:0] reg_write_address_in;
    logic [DATA_W-1:0] alu_value_in;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] LDM_value_in;
    logic [DATA_W-1:0] input_port_in;
    logic [DATA_W-1:0] read_data1_in;
    logic              outport_enable_in;
    logic              out_ready;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_address;
    logic [DATA_W-1:0] reg_write_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              outport_stall;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output reg_write_in, wb_sel_in, reg_write_address_in, alu_value_in, mem_data_in,
               LDM_value_in, input_port_in, read_data1_in, outport_enable_in, out_ready,
        input  reg_write_en, reg_write_address, reg_write_data, out_valid, out_data,
               outport_stall, out_count
    );

    modport slave (
        input  reg_write_in, wb_sel_in, reg_write_address_in, alu_value_in, mem_data_in,
               LDM_value_in, input_port_in, read_data1_in, outport_enable_in, out_ready,
        output reg_write_en, reg_write_address, reg_write_data, out_valid, out_data,
               outport_stall, out_count
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: combinational register-file write-back plus a small circular
// FIFO that owns the output port and back-pressures the pipeline when it cannot accept.
module writeback_stage #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int OUT_DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    writeback_stage_if.slave wb
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, empty, push, pop, stall;

    always_comb begin
        wb.reg_write_data = wb.alu_value_in;
        case (wb.wb_sel_in)
            2'b00: wb.reg_write_data = wb.alu_value_in;
            2'b01: wb.reg_write_data = wb.mem_data_in;
            2'b10: wb.reg_write_data = wb.LDM_value_in;
            2'b11: wb.reg_write_data = wb.input_port_in;
        endcase
    end

    assign full  = (count == CNT_W'(OUT_DEPTH));
    assign empty = (count == '0);
    assign pop   = ~empty & wb.out_ready;
    // A full FIFO still takes the new entry when the head leaves in the same cycle.
    assign push  = wb.outport_enable_in & (~full | wb.out_ready);
    assign stall = wb.outport_enable_in & full & ~wb.out_ready;

    assign wb.reg_write_address = wb.reg_write_address_in;
    assign wb.reg_write_en      = wb.reg_write_in & reset & ~stall;
    assign wb.outport_stall     = stall;
    assign wb.out_valid         = ~empty;
    assign wb.out_data          = fifo_mem[rd_ptr];
    assign wb.out_count         = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it until count says an entry is live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wb.read_data1_in;
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized checks of writeback_stage against a queue-based model
// of the write-back mux and output FIFO.
module tb_writeback_stage;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    writeback_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_DEPTH(DEPTH)) bus ();

    writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int max_cnt = 0;
    logic last_push;
    logic [15:0] mq[$];
    logic [15:0] got[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at posedge+1 with inputs already driven; checks, then advances one clock.
    task automatic drive_cycle();
        logic full_m, exp_pop, exp_push, exp_stall;
        logic [15:0] src [4];
        logic [15:0] tmp;
        #2;
        full_m    = (mq.size() == DEPTH);
        exp_pop   = (mq.size() != 0) && bus.out_ready;
        exp_push  = bus.outport_enable_in && (!full_m || bus.out_ready);
        exp_stall = bus.outport_enable_in && full_m && !bus.out_ready;
        src = '{bus.alu_value_in, bus.mem_data_in, bus.LDM_value_in, bus.input_port_in};
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check("out_count", 32'(bus.out_count), mq.size());
        if (int'(bus.out_count) > max_cnt) max_cnt = int'(bus.out_count);
        if (mq.size() != 0) check("out_data", 32'(bus.out_data), 32'(mq[0]));
        check("stall", 32'(bus.outport_stall), 32'(exp_stall));
        check("wr_en", 32'(bus.reg_write_en), 32'(bus.reg_write_in && !exp_stall));
        check("wr_data", 32'(bus.reg_write_data), 32'(src[bus.wb_sel_in]));
        check("wr_addr", 32'(bus.reg_write_address), 32'(bus.reg_write_address_in));
        if (exp_pop) got.push_back(bus.out_data);
        last_push = exp_push;
        @(posedge clk); #1;
        if (exp_pop) tmp = mq.pop_front();
        if (exp_push) mq.push_back(bus.read_data1_in);
    endtask

    task automatic set_out(input logic en, input logic [15:0] d, input logic rdy);
        bus.outport_enable_in = en;
        bus.read_data1_in = d;
        bus.out_ready = rdy;
    endtask

    initial begin
        int idx;
        bus.reg_write_in = 1'b1;
        bus.wb_sel_in = 2'b00;
        bus.reg_write_address_in = 3'd5;
        bus.alu_value_in = 16'h1111;
        bus.mem_data_in = 16'h2222;
        bus.LDM_value_in = 16'h3333;
        bus.input_port_in = 16'h4444;
        set_out(1'b0, 16'h0, 1'b0);

        // Reset state, including a write request held off by reset
        #3;
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_count", 32'(bus.out_count), 0);
        check("rst_stall", 32'(bus.outport_stall), 0);
        check("rst_wr_en", 32'(bus.reg_write_en), 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Write-back mux sweep
        for (int s = 0; s < 4; s++) begin
            bus.wb_sel_in = 2'(s);
            #1;
            check("mux_data", 32'(bus.reg_write_data), 32'(16'h1111 * (s + 1)));
            check("mux_addr", 32'(bus.reg_write_address), 5);
            check("mux_en", 32'(bus.reg_write_en), 1);
            #1;
            drive_cycle();
        end

        // Single OUT, one-cycle latency
        set_out(1'b1, 16'hBEEF, 1'b0);
        drive_cycle();
        set_out(1'b0, 16'h0, 1'b0);
        #1;
        check("single_valid", 32'(bus.out_valid), 1);
        check("single_data", 32'(bus.out_data), 32'h BEEF);
        check("single_count", 32'(bus.out_count), 1);
        #1;
        bus.out_ready = 1'b1;
        drive_cycle();
        bus.out_ready = 1'b0;
        drive_cycle();

        // Fill to full, stall on the fifth, release with same-cycle push/pop
        got.delete();
        for (int i = 0; i < 4; i++) begin
            set_out(1'b1, 16'(8'hA0 + i), 1'b0);
            drive_cycle();
        end
        set_out(1'b1, 16'h00A4, 1'b0);
        #1;
        check("fill_count", 32'(bus.out_count), 4);
        check("fill_stall", 32'(bus.outport_stall), 1);
        check("fill_wr_en", 32'(bus.reg_write_en), 0);
        #1;
        drive_cycle();
        drive_cycle();
        bus.out_ready = 1'b1;
        drive_cycle();
        set_out(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 5; i++) drive_cycle();
        check("fill_delivered", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++)
            check("fill_order", 32'(got[i]), 32'(8'hA0 + i));

        // Wrap-around with toggling ready; stalled values are re-presented
        got.delete();
        max_cnt = 0;
        idx = 0;
        for (int c = 0; c < 60 && idx < 10; c++) begin
            set_out(1'b1, 16'(idx), c[0]);
            drive_cycle();
            if (last_push) idx++;
        end
        check("wrap_sent", idx, 10);
        set_out(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 6; i++) drive_cycle();
        check("wrap_delivered", got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++)
            check("wrap_order", 32'(got[i]), i);
        check("wrap_max_count", 32'(max_cnt <= DEPTH), 1);

        // Asynchronous reset mid-drain discards entries
        for (int i = 0; i < 3; i++) begin
            set_out(1'b1, 16'(16'hC0 + i), 1'b0);
            drive_cycle();
        end
        set_out(1'b0, 16'h0, 1'b0);
        #1;
        check("pre_rst_count", 32'(bus.out_count), 3);
        check("pre_rst_valid", 32'(bus.out_valid), 1);
        #1;
        bus.out_ready = 1'b1;
        bus.reg_write_in = 1'b1;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_count", 32'(bus.out_count), 0);
        check("arst_wr_en", 32'(bus.reg_write_en), 0);
        mq.delete();
        @(negedge clk) reset = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        set_out(1'b1, 16'h5A5A, 1'b0);
        drive_cycle();
        set_out(1'b0, 16'h0, 1'b0);
        #1;
        check("post_rst_data", 32'(bus.out_data), 32'h5A5A);
        check("post_rst_count", 32'(bus.out_count), 1);
        #1;
        bus.out_ready = 1'b1;
        drive_cycle();

        // Randomized traffic against the model
        for (int c = 0; c < 300; c++) begin
            bus.reg_write_in = 1'($urandom);
            bus.wb_sel_in = 2'($urandom);
            bus.reg_write_address_in = 3'($urandom);
            bus.alu_value_in = 16'($urandom);
            bus.mem_data_in = 16'($urandom);
            bus.LDM_value_in = 16'($urandom);
            bus.input_port_in = 16'($urandom);
            set_out(1'($urandom), 16'($urandom), ($urandom_range(0, 2) != 0));
            drive_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
